// File: rtl/writeback_arbiter.sv
// writeback_arbiter: two-source (ALU, MEM) FIFO'd round-robin writeback onto one register-bank write port.
//   clock/resetN               : rising-edge clock, asynchronous active-low reset
//   aluValid/aluReady/aluReg/aluData, memValid/memReady/memReg/memData : source request handshakes
//   regC/dataWrite/writeFlag   : bank write port, all zero when nothing is granted
//   pendingMask                : bit r set while any queued write targets r
//   idle                       : both FIFOs empty
module writeback_arbiter #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       aluValid,
  output logic                       aluReady,
  input  logic [ADDR_WIDTH-1:0]      aluReg,
  input  logic [DATA_WIDTH-1:0]      aluData,
  input  logic                       memValid,
  output logic                       memReady,
  input  logic [ADDR_WIDTH-1:0]      memReg,
  input  logic [DATA_WIDTH-1:0]      memData,
  output logic [ADDR_WIDTH-1:0]      regC,
  output logic [DATA_WIDTH-1:0]      dataWrite,
  output logic                       writeFlag,
  output logic [(1<<ADDR_WIDTH)-1:0] pendingMask,
  output logic                       idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 1 << ADDR_WIDTH;
  // index 0 is the ALU source, index 1 the MEM source
  logic [ADDR_WIDTH-1:0] reg_q [2][DEPTH], reg_d [2][DEPTH];
  logic [DATA_WIDTH-1:0] data_q [2][DEPTH], data_d [2][DEPTH];
  logic [PW-1:0] wp_q [2], wp_d [2], rp_q [2], rp_d [2];
  logic [CW-1:0] cnt_q [2], cnt_d [2];
  logic last_q, last_d;
  logic [NR-1:0] pend [2];
  logic [ADDR_WIDTH-1:0] in_reg [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [1:0] push, pop, ne;
  logic conflict;
  assign in_reg[0]  = aluReg;
  assign in_reg[1]  = memReg;
  assign in_data[0] = aluData;
  assign in_data[1] = memData;
  // an entry is live when its distance from the read pointer is below the count
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      pend[s] = '0;
      for (int i = 0; i < DEPTH; i++)
        if ({1'b0, PW'(i) - rp_q[s]} < cnt_q[s]) pend[s][reg_q[s][i]] = 1'b1;
    end
  end
  // ALU wins a same-cycle same-register tie, so the FIFOs never share a register
  assign aluReady = (cnt_q[0] != CW'(DEPTH)) & ~pend[1][aluReg];
  assign conflict = aluValid & aluReady & (aluReg == memReg) & (memReg != '0);
  assign memReady = (cnt_q[1] != CW'(DEPTH)) & ~pend[0][memReg] & ~conflict;
  // register 0 is handshaken but never queued
  assign push[0] = aluValid & aluReady & (aluReg != '0);
  assign push[1] = memValid & memReady & (memReg != '0);
  assign ne[0] = cnt_q[0] != '0;
  assign ne[1] = cnt_q[1] != '0;
  assign pop[0] = ne[0] & (~ne[1] | last_q);
  assign pop[1] = ne[1] & (~ne[0] | ~last_q);
  assign writeFlag   = |pop;
  assign regC        = pop[0] ? reg_q[0][rp_q[0]] : pop[1] ? reg_q[1][rp_q[1]] : '0;
  assign dataWrite   = pop[0] ? data_q[0][rp_q[0]] : pop[1] ? data_q[1][rp_q[1]] : '0;
  assign pendingMask = pend[0] | pend[1];
  assign idle        = ~|ne;
  always_comb begin
    last_d = pop[1] ? 1'b1 : pop[0] ? 1'b0 : last_q;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_d[s][i]  = reg_q[s][i];
        data_d[s][i] = data_q[s][i];
      end
      if (push[s]) begin
        reg_d[s][wp_q[s]]  = in_reg[s];
        data_d[s][wp_q[s]] = in_data[s];
      end
      wp_d[s]  = wp_q[s] + PW'(push[s]);
      rp_d[s]  = rp_q[s] + PW'(pop[s]);
      cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
    end
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      last_q <= 1'b1;
      for (int s = 0; s < 2; s++) begin
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        cnt_q[s] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          reg_q[s][i]  <= '0;
          data_q[s][i] <= '0;
        end
      end
    end else begin
      last_q <= last_d;
      for (int s = 0; s < 2; s++) begin
        wp_q[s]  <= wp_d[s];
        rp_q[s]  <= rp_d[s];
        cnt_q[s] <= cnt_d[s];
        for (int i = 0; i < DEPTH; i++) begin
          reg_q[s][i]  <= reg_d[s][i];
          data_q[s][i] <= data_d[s][i];
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: table-driven check of writeback_arbiter plus reset sequences.
module tb_writeback_arbiter;
  logic clock, resetN;
  logic alu_valid, alu_ready, mem_valid, mem_ready, write_flag, idle;
  logic [4:0] alu_reg, mem_reg, reg_c;
  logic [31:0] alu_data, mem_data, data_write, pending_mask;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic e_ardy, e_mrdy, e_wf; logic [4:0] e_rc; logic [31:0] e_dw, e_pm; logic e_idle;
  } vec_t;
  vec_t vq[$];
  writeback_arbiter dut (
    .clock(clock), .resetN(resetN),
    .aluValid(alu_valid), .aluReady(alu_ready), .aluReg(alu_reg), .aluData(alu_data),
    .memValid(mem_valid), .memReady(mem_ready), .memReg(mem_reg), .memData(mem_data),
    .regC(reg_c), .dataWrite(data_write), .writeFlag(write_flag),
    .pendingMask(pending_mask), .idle(idle)
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md,
                              input logic ardy, input logic mrdy, input logic wf,
                              input logic [4:0] rc, input logic [31:0] dw, input logic [31:0] pm,
                              input logic idl);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.e_ardy = ardy; v.e_mrdy = mrdy; v.e_wf = wf; v.e_rc = rc; v.e_dw = dw; v.e_pm = pm; v.e_idle = idl;
    return v;
  endfunction
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask
  task automatic check_outs(input string tag, input logic ardy, input logic mrdy, input logic wf,
                            input logic [4:0] rc, input logic [31:0] dw, input logic [31:0] pm,
                            input logic idl);
    chk({tag, ".aluReady"}, 32'(alu_ready), 32'(ardy));
    chk({tag, ".memReady"}, 32'(mem_ready), 32'(mrdy));
    chk({tag, ".writeFlag"}, 32'(write_flag), 32'(wf));
    chk({tag, ".regC"}, 32'(reg_c), 32'(rc));
    chk({tag, ".dataWrite"}, data_write, dw);
    chk({tag, ".pendingMask"}, pending_mask, pm);
    chk({tag, ".idle"}, 32'(idle), 32'(idl));
  endtask
  initial begin
    // single write, register 0, ordering, then round-robin contention and drain
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,0,0,0,0,1));
    vq.push_back(mk(1,7,32'hDEADBEEF,0,0,0,    1,1,0,0,0,0,1));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,1,7,32'hDEADBEEF,32'h80,0));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,0,0,0,0,1));
    vq.push_back(mk(1,0,32'hFFFF,    0,0,0,    1,1,0,0,0,0,1));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,0,0,0,0,1));
    vq.push_back(mk(0,0,0,           1,5,32'hAA,1,1,0,0,0,0,1));
    vq.push_back(mk(1,5,32'hBB,      0,0,0,    0,1,1,5,32'hAA,32'h20,0));
    vq.push_back(mk(1,5,32'hBB,      0,0,0,    1,1,0,0,0,0,1));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,1,5,32'hBB,32'h20,0));
    vq.push_back(mk(1,9,1,           1,9,2,    1,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,           1,9,2,    1,0,1,9,1,32'h200,0));
    vq.push_back(mk(0,0,0,           1,9,2,    1,1,0,0,0,0,1));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,1,9,2,32'h200,0));
    vq.push_back(mk(1,1,32'h11,      1,2,32'h22,1,1,0,0,0,0,1));
    vq.push_back(mk(1,1,32'h11,      1,2,32'h22,1,1,1,1,32'h11,32'h6,0));
    vq.push_back(mk(1,1,32'h11,      1,2,32'h22,1,0,1,2,32'h22,32'h6,0));
    vq.push_back(mk(1,1,32'h11,      1,2,32'h22,0,1,1,1,32'h11,32'h6,0));
    vq.push_back(mk(1,1,32'h11,      1,2,32'h22,1,0,1,2,32'h22,32'h6,0));
    vq.push_back(mk(1,1,32'h11,      1,2,32'h22,0,1,1,1,32'h11,32'h6,0));
    vq.push_back(mk(0,0,0,           0,0,0,    1,0,1,2,32'h22,32'h6,0));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,1,1,32'h11,32'h6,0));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,1,2,32'h22,32'h4,0));
    vq.push_back(mk(0,0,0,           0,0,0,    1,1,0,0,0,0,1));
    // reset with no clock edge yet
    resetN = 0;
    drive(0,0,0,0,0,0);
    #1;
    check_outs("reset", 1,1,0,0,0,0,1);
    @(negedge clock);
    resetN = 1;
    @(posedge clock); #1;
    foreach (vq[i]) begin
      drive(vq[i].av, vq[i].ar, vq[i].ad, vq[i].mv, vq[i].mr, vq[i].md);
      @(negedge clock);
      check_outs($sformatf("vec%0d", i), vq[i].e_ardy, vq[i].e_mrdy, vq[i].e_wf,
                 vq[i].e_rc, vq[i].e_dw, vq[i].e_pm, vq[i].e_idle);
      @(posedge clock); #1;
    end
    // mid-stream reset: both sources queued, reset pulsed between edges
    drive(1,1,32'h11,1,2,32'h22);
    repeat (2) begin
      @(posedge clock); #1;
    end
    chk("mid.wf_before", 32'(write_flag), 32'd1);
    chk("mid.regC_before", 32'(reg_c), 32'd2);
    drive(0,0,0,0,0,0);
    #2 resetN = 0;
    #1;
    check_outs("midreset", 1,1,0,0,0,0,1);
    @(negedge clock);
    resetN = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk($sformatf("post%0d.writeFlag", k), 32'(write_flag), 32'd0);
      chk($sformatf("post%0d.idle", k), 32'(idle), 32'd1);
    end
    // after reset the ALU wins the first contention
    drive(1,3,32'h33,1,4,32'h44);
    @(posedge clock); #1;
    drive(0,0,0,0,0,0);
    chk("first.writeFlag", 32'(write_flag), 32'd1);
    chk("first.regC", 32'(reg_c), 32'd3);
    chk("first.dataWrite", data_write, 32'h33);
    @(posedge clock); #1;
    chk("second.regC", 32'(reg_c), 32'd4);
    chk("second.dataWrite", data_write, 32'h44);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
